// File: rtl/hci_ecc_source_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hci_ecc_source_ctrl
// Purpose  : Launch/enable sequencer for hci_ecc_source with ECC error counting,
//            abort-on-uncorrectable and optional relaunch
//            (macro HCI_ECC_SOURCE_CTRL_RETRY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module hci_ecc_source_ctrl #(
    parameter int N_CHUNK   = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic               src_ready_start_i,
    input  logic               src_done_i,
    output logic               src_req_start_o,
    output logic               src_enable_o,
    output logic               src_clear_o,
    input  logic [N_CHUNK-1:0] r_data_single_err_i,
    input  logic [N_CHUNK-1:0] r_data_multi_err_i,
    input  logic               r_meta_single_err_i,
    input  logic               r_meta_multi_err_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               fatal_o,
    output logic [CNT_W-1:0]   single_err_cnt_o,
    output logic [CNT_W-1:0]   multi_err_cnt_o,
    output logic [3:0]         retry_cnt_o
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        LAUNCH        = 3'd1,
        RUN           = 3'd2,
        ABORT         = 3'd3,
        RELAUNCH_WAIT = 3'd4,
        FATAL         = 3'd5
    } state_t;

    // Wide enough to hold the counter plus one full per-cycle increment.
    localparam int SUM_W = CNT_W + $clog2(N_CHUNK + 2);
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
    localparam logic [3:0] RETRY_LIMIT = 4'((MAX_RETRY > 15) ? 15 : MAX_RETRY);
`ifdef HCI_ECC_SOURCE_CTRL_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    state_t             state, state_nxt;
    logic               done_nxt;
    logic [CNT_W-1:0]   single_cnt, single_nxt;
    logic [CNT_W-1:0]   multi_cnt, multi_nxt;
    logic [3:0]         retry_cnt, retry_nxt;
    logic [SUM_W-1:0]   single_inc;
    logic [SUM_W-1:0]   single_sum;
    logic               multi_hit;

    always_comb begin
        single_inc = SUM_W'(r_meta_single_err_i);
        for (int i = 0; i < N_CHUNK; i++) begin
            single_inc = single_inc + SUM_W'(r_data_single_err_i[i]);
        end
    end

    assign single_sum = {{(SUM_W-CNT_W){1'b0}}, single_cnt} + single_inc;
    assign multi_hit  = (|r_data_multi_err_i) | r_meta_multi_err_i;

    always_comb begin
        state_nxt       = state;
        done_nxt        = 1'b0;
        single_nxt      = single_cnt;
        multi_nxt       = multi_cnt;
        retry_nxt       = retry_cnt;
        src_req_start_o = 1'b0;
        src_enable_o    = 1'b0;
        src_clear_o     = clear_i;

        case (state)
            IDLE: begin
                if (start_i && src_ready_start_i) begin
                    state_nxt  = LAUNCH;
                    single_nxt = '0;
                    multi_nxt  = '0;
                    retry_nxt  = '0;
                end
            end
            LAUNCH: begin
                src_req_start_o = 1'b1;
                src_enable_o    = 1'b1;
                state_nxt       = RUN;
            end
            RUN: begin
                src_enable_o = 1'b1;
                single_nxt   = (single_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                                      : single_sum[CNT_W-1:0];
                // An uncorrectable error outranks a coincident done pulse.
                if (multi_hit) begin
                    if (multi_cnt != {CNT_W{1'b1}}) begin
                        multi_nxt = multi_cnt + CNT_W'(1);
                    end
                    state_nxt = ABORT;
                end else if (src_done_i) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ABORT: begin
                src_clear_o = 1'b1;
                if (RETRY_EN && (retry_cnt < RETRY_LIMIT)) begin
                    retry_nxt = retry_cnt + 4'd1;
                    state_nxt = RELAUNCH_WAIT;
                end else begin
                    state_nxt = FATAL;
                end
            end
`ifdef HCI_ECC_SOURCE_CTRL_RETRY_EN
            RELAUNCH_WAIT: begin
                if (src_ready_start_i) begin
                    state_nxt = LAUNCH;
                end
            end
`endif
            FATAL: begin
                state_nxt = FATAL;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (clear_i) begin
            state_nxt  = IDLE;
            done_nxt   = 1'b0;
            single_nxt = '0;
            multi_nxt  = '0;
            retry_nxt  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
            fatal_o    <= 1'b0;
            single_cnt <= '0;
            multi_cnt  <= '0;
            retry_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            done_o     <= done_nxt;
            // Status flags follow the state being entered so they line up with it.
            busy_o     <= (state_nxt != IDLE) && (state_nxt != FATAL);
            fatal_o    <= (state_nxt == FATAL);
            single_cnt <= single_nxt;
            multi_cnt  <= multi_nxt;
            retry_cnt  <= retry_nxt;
        end
    end

    assign single_err_cnt_o = single_cnt;
    assign multi_err_cnt_o  = multi_cnt;
`ifdef HCI_ECC_SOURCE_CTRL_RETRY_EN
    assign retry_cnt_o      = retry_cnt;
`else
    assign retry_cnt_o      = 4'd0;
`endif

endmodule
`default_nettype wire
